// File: rtl/cache_req_arbiter_if.sv
// cache_req_arbiter_if: requester, cache and statistics signals; master = arbiter side, slave = requesters/cache side
interface cache_req_arbiter_if #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 12
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ready;
  logic                   cache_valid;
  logic                   cache_ready;
  logic [ADDR_W-1:0]      cache_addr;
  logic                   cache_write;
  logic                   cache_done;
  logic                   cache_hit;
  logic [NREQ-1:0]        resp_valid;
  logic                   resp_hit;
  logic                   resp_err;
  logic [CNT_W-1:0]       num_reads;
  logic [CNT_W-1:0]       num_writes;
  logic [CNT_W-1:0]       num_misses;
  modport master (
    input  req_valid, req_write, req_addr, cache_ready, cache_done, cache_hit,
    output req_ready, cache_valid, cache_addr, cache_write, resp_valid, resp_hit, resp_err,
           num_reads, num_writes, num_misses
  );
  modport slave (
    output req_valid, req_write, req_addr, cache_ready, cache_done, cache_hit,
    input  req_ready, cache_valid, cache_addr, cache_write, resp_valid, resp_hit, resp_err,
           num_reads, num_writes, num_misses
  );
endinterface

// File: rtl/cache_req_arbiter.sv
// cache_req_arbiter: round-robin sharing of one cache lookup engine; ports clk, reset (sync, active-high), bus (master side of cache_req_arbiter_if)
module cache_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 12,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  cache_req_arbiter_if.master bus
);
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            r_state;
  logic [GW-1:0]     r_rr_ptr;
  logic [GW-1:0]     r_grant;
  logic [GW-1:0]     w_gnt;
  logic [GW-1:0]     w_idx;
  logic              w_any;
  logic [7:0]        r_wait_cnt;
  logic              r_hit;
  logic              r_err;
  logic              r_cache_valid;
  logic              r_cache_write;
  logic [ADDR_W-1:0] r_cache_addr;
  logic [NREQ-1:0]   r_resp_valid;
  logic [CNT_W-1:0]  r_num_reads;
  logic [CNT_W-1:0]  r_num_writes;
  logic [CNT_W-1:0]  r_num_misses;
  // scan from the farthest offset down so the nearest set requester after rr_ptr wins
  always_comb begin
    w_any = 1'b0;
    w_gnt = r_rr_ptr;
    w_idx = r_rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_idx = GW'((int'(r_rr_ptr) + i) % NREQ);
      if (bus.req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end
  assign bus.req_ready   = (r_state == IDLE && w_any) ? NREQ'(1) << w_gnt : '0;
  assign bus.cache_valid = r_cache_valid;
  assign bus.cache_addr  = r_cache_addr;
  assign bus.cache_write = r_cache_write;
  assign bus.resp_valid  = r_resp_valid;
  assign bus.resp_hit    = r_hit;
  assign bus.resp_err    = r_err;
  assign bus.num_reads   = r_num_reads;
  assign bus.num_writes  = r_num_writes;
  assign bus.num_misses  = r_num_misses;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rr_ptr      <= '0;
      r_grant       <= '0;
      r_wait_cnt    <= '0;
      r_hit         <= 1'b0;
      r_err         <= 1'b0;
      r_cache_valid <= 1'b0;
      r_cache_write <= 1'b0;
      r_cache_addr  <= '0;
      r_resp_valid  <= '0;
      r_num_reads   <= '0;
      r_num_writes  <= '0;
      r_num_misses  <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_cache_addr  <= bus.req_addr[int'(w_gnt) * ADDR_W +: ADDR_W];
          r_cache_write <= bus.req_write[w_gnt];
          r_grant       <= w_gnt;
          r_cache_valid <= 1'b1;
          r_state       <= ISSUE;
        end
        ISSUE: if (bus.cache_ready) begin
          r_cache_valid <= 1'b0;
          r_wait_cnt    <= '0;
          r_state       <= WAIT;
        end
        WAIT: begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
          // a completion arriving on the timeout cycle is still a normal completion
          if (bus.cache_done || r_wait_cnt == 8'(TIMEOUT - 1)) begin
            r_hit        <= bus.cache_done & bus.cache_hit;
            r_err        <= ~bus.cache_done;
            r_resp_valid <= NREQ'(1) << r_grant;
            r_state      <= RESP;
          end
        end
        RESP: begin
          r_resp_valid <= '0;
          r_num_reads  <= r_num_reads + CNT_W'(!r_cache_write && r_num_reads != '1);
          r_num_writes <= r_num_writes + CNT_W'(r_cache_write && r_num_writes != '1);
          r_num_misses <= r_num_misses + CNT_W'(!r_hit && r_num_misses != '1);
          r_rr_ptr     <= (int'(r_grant) == NREQ - 1) ? '0 : r_grant + 1'b1;
          r_state      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb_cache_req_arbiter: directed and randomized checks of cache_req_arbiter against a transaction-level model
module tb_cache_req_arbiter;
  localparam int N = 3, AW = 32, CW = 4, TO = 8;
  localparam int CMAX = (1 << CW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cache_req_arbiter_if #(.NREQ(N), .ADDR_W(AW), .CNT_W(CW)) bus();
  cache_req_arbiter #(.NREQ(N), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bus(bus.master)
  );
  int n_pass = 0, n_tot = 0;
  int m_rr = 0, m_g = 0, m_waited = 0, m_reads = 0, m_writes = 0, m_misses = 0;
  bit m_busy = 0, m_issued = 0, m_resp = 0, m_write = 0, m_hit = 0, m_err = 0;
  logic [AW-1:0] m_addr = '0;
  logic [N-1:0]  s_req_ready, s_resp_valid;
  logic          s_cache_valid, s_cache_write, s_resp_hit, s_resp_err;
  logic [AW-1:0] s_cache_addr;
  logic [CW-1:0] s_reads, s_writes, s_misses;
  int gq[$];
  logic [AW-1:0] aq[$];
  int grants;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask
  // sample and compare at negedge+1, then advance the model by what the next posedge will see
  task automatic cyc();
    int eg = -1;
    #1;
    s_req_ready = bus.req_ready; s_resp_valid = bus.resp_valid;
    s_cache_valid = bus.cache_valid; s_cache_write = bus.cache_write; s_cache_addr = bus.cache_addr;
    s_resp_hit = bus.resp_hit; s_resp_err = bus.resp_err;
    s_reads = bus.num_reads; s_writes = bus.num_writes; s_misses = bus.num_misses;
    if (!m_busy)
      for (int i = 0; i < N; i++)
        if (eg < 0 && bus.req_valid[(m_rr + i) % N]) eg = (m_rr + i) % N;
    chk("req_ready", s_req_ready, eg >= 0 ? 64'(1) << eg : 64'd0);
    chk("cache_valid", s_cache_valid, m_busy && !m_issued);
    chk("cache_addr", s_cache_addr, m_addr);
    chk("cache_write", s_cache_write, m_write);
    chk("resp_valid", s_resp_valid, m_resp ? 64'(1) << m_g : 64'd0);
    if (m_resp) begin
      chk("resp_hit", s_resp_hit, m_hit);
      chk("resp_err", s_resp_err, m_err);
    end
    chk("num_reads", s_reads, m_reads);
    chk("num_writes", s_writes, m_writes);
    chk("num_misses", s_misses, m_misses);
    if (reset) begin
      m_rr = 0; m_g = 0; m_waited = 0; m_reads = 0; m_writes = 0; m_misses = 0;
      m_busy = 0; m_issued = 0; m_resp = 0; m_write = 0; m_hit = 0; m_err = 0; m_addr = '0;
    end else if (m_resp) begin
      if (!m_write) m_reads = m_reads < CMAX ? m_reads + 1 : CMAX;
      if (m_write) m_writes = m_writes < CMAX ? m_writes + 1 : CMAX;
      if (!m_hit) m_misses = m_misses < CMAX ? m_misses + 1 : CMAX;
      m_rr = (m_g + 1) % N; m_busy = 0; m_resp = 0;
    end else if (m_busy && !m_issued) begin
      if (bus.cache_ready) begin m_issued = 1; m_waited = 0; end
    end else if (m_busy) begin
      m_waited++;
      if (bus.cache_done) begin m_resp = 1; m_hit = bus.cache_hit; m_err = 0; end
      else if (m_waited == TO) begin m_resp = 1; m_hit = 0; m_err = 1; end
    end else if (eg >= 0) begin
      m_busy = 1; m_issued = 0; m_g = eg;
      m_addr = bus.req_addr[eg * AW +: AW]; m_write = bus.req_write[eg];
    end
    @(negedge clk);
  endtask
  initial begin
    bus.req_valid = '0; bus.req_write = '0; bus.req_addr = '0;
    bus.cache_ready = 0; bus.cache_done = 0; bus.cache_hit = 0;
    @(negedge clk);
    cyc(); cyc();
    reset = 0;
    // single read from requester 0
    bus.req_valid = 3'b001; bus.req_addr[0 +: AW] = 32'h0000_1040; bus.cache_ready = 1;
    cyc();
    chk("t1_ready_T", s_req_ready, 1);
    chk("t1_cv_T", s_cache_valid, 0);
    bus.req_valid = '0;
    cyc();
    chk("t1_cv_T1", s_cache_valid, 1);
    chk("t1_addr_T1", s_cache_addr, 32'h0000_1040);
    bus.cache_done = 1; bus.cache_hit = 1;
    cyc();
    bus.cache_done = 0; bus.cache_hit = 0;
    cyc();
    chk("t1_resp_T3", s_resp_valid, 3'b001);
    chk("t1_hit_T3", s_resp_hit, 1);
    cyc();
    chk("t1_reads", s_reads, 1);
    chk("t1_misses", s_misses, 0);
    // two requesters contending continuously
    reset = 1; cyc(); reset = 0;
    bus.req_valid = 3'b011; bus.req_addr[0 +: AW] = 32'h100; bus.req_addr[AW +: AW] = 32'h200;
    bus.cache_done = 1; bus.cache_hit = 1;
    for (int c = 0; c < 40 && gq.size() < 4; c++) begin
      cyc();
      if (s_req_ready != 0) gq.push_back(s_req_ready == 3'b001 ? 0 : s_req_ready == 3'b010 ? 1 : 2);
      if (s_cache_valid) aq.push_back(s_cache_addr);
    end
    bus.req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      cyc();
      if (s_cache_valid) aq.push_back(s_cache_addr);
    end
    chk("t2_ngrants", gq.size(), 4);
    chk("t2_naddr", aq.size(), 4);
    for (int i = 0; i < 4 && i < gq.size() && i < aq.size(); i++) begin
      chk("t2_grant", gq[i], i % 2);
      chk("t2_addr", aq[i], (i % 2) ? 32'h200 : 32'h100);
    end
    // ISSUE stall, then timeout, then stray completions
    bus.cache_done = 0; bus.cache_hit = 0; bus.cache_ready = 0;
    bus.req_valid = 3'b001; bus.req_addr[0 +: AW] = 32'h3333;
    cyc();
    chk("t3_grant", s_req_ready, 3'b001);
    bus.req_valid = '0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("t3_stall_cv", s_cache_valid, 1);
      chk("t3_stall_addr", s_cache_addr, 32'h3333);
    end
    bus.cache_ready = 1;
    cyc();
    chk("t3_hs_cv", s_cache_valid, 1);
    bus.cache_ready = 0;
    for (int c = 0; c < TO; c++) begin
      cyc();
      chk("t3_wait_rv", s_resp_valid, 0);
    end
    cyc();
    chk("t3_to_rv", s_resp_valid, 3'b001);
    chk("t3_to_hit", s_resp_hit, 0);
    chk("t3_to_err", s_resp_err, 1);
    bus.cache_done = 1; bus.cache_hit = 1;
    cyc(); cyc(); cyc();
    chk("t3_stray_rv", s_resp_valid, 0);
    chk("t3_misses", s_misses, 1);
    chk("t3_reads", s_reads, 5);
    bus.cache_done = 0; bus.cache_hit = 0;
    // counter saturation with 20 write misses
    reset = 1; cyc(); reset = 0;
    bus.req_valid = 3'b010; bus.req_write = 3'b010; bus.req_addr[AW +: AW] = 32'hABC;
    bus.cache_ready = 1; bus.cache_done = 1; bus.cache_hit = 0;
    grants = 0;
    for (int c = 0; c < 200 && grants < 20; c++) begin
      cyc();
      if (s_req_ready != 0) grants++;
    end
    bus.req_valid = '0; bus.req_write = '0;
    for (int c = 0; c < 6; c++) cyc();
    chk("t4_grants", grants, 20);
    chk("t4_writes", s_writes, 15);
    chk("t4_misses", s_misses, 15);
    chk("t4_reads", s_reads, 0);
    // reset while waiting abandons the request and restarts arbitration at 0
    reset = 1; cyc(); reset = 0;
    bus.req_valid = 3'b001; bus.cache_hit = 1;
    grants = 0;
    for (int c = 0; c < 10 && grants < 1; c++) begin
      cyc();
      if (s_req_ready != 0) grants++;
    end
    bus.req_valid = '0;
    for (int c = 0; c < 4; c++) cyc();
    bus.cache_done = 0; bus.req_valid = 3'b010;
    cyc();
    chk("t5_grant1", s_req_ready, 3'b010);
    bus.req_valid = '0;
    cyc(); cyc();
    reset = 1; cyc(); reset = 0;
    cyc();
    chk("t5_cv", s_cache_valid, 0);
    chk("t5_rv", s_resp_valid, 0);
    chk("t5_addr", s_cache_addr, 0);
    chk("t5_reads", s_reads, 0);
    bus.cache_done = 1;
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("t5_late_rv", s_resp_valid, 0);
    end
    bus.cache_done = 0; bus.req_valid = 3'b011;
    cyc();
    chk("t5_grant0", s_req_ready, 3'b001);
    bus.req_valid = '0;
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(199) == 0);
      for (int k = 0; k < N; k++) begin
        if (!bus.req_valid[k]) begin
          if ($urandom_range(3) == 0) begin
            bus.req_valid[k] = 1'b1;
            bus.req_addr[k * AW +: AW] = $urandom;
            bus.req_write[k] = 1'($urandom_range(1));
          end
        end else if ($urandom_range(15) == 0) bus.req_valid[k] = 1'b0;
      end
      bus.cache_ready = 1'($urandom_range(1));
      bus.cache_done = ($urandom_range(9) < 3);
      bus.cache_hit = 1'($urandom_range(1));
      cyc();
      for (int k = 0; k < N; k++) if (s_req_ready[k]) bus.req_valid[k] = 1'b0;
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/cache_req_arbiter.md
Name: cache_req_arbiter

Overview:
- Round-robin arbiter and sequencer sharing one cache lookup engine between NREQ requesters (e.g. instruction and data trace streams).
- Accepts one request at a time, issues its address/type to the cache over a valid/ready handshake, and waits for the cache to signal completion.
- Routes the hit/miss result back to the winning requester and keeps saturating read, write and miss statistics.
- Sits between the trace/request sources and the cache datapath.

Parameters:
- NREQ, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- CNT_W, 12, statistics counter width.
- TIMEOUT, 255, maximum cycles spent in WAIT before forcing an error response (1..255).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_write  in  NREQ  1 = write, 0 = read, per requester.
- req_addr  in  NREQ*ADDR_W  flattened addresses; requester k occupies bits [k*ADDR_W +: ADDR_W].
- req_ready  out  NREQ  one-hot accept pulse to the granted requester.
- cache_valid  out  1  lookup request to the cache.
- cache_ready  in  1  cache accepts the lookup.
- cache_addr  out  ADDR_W  latched address of the granted request.
- cache_write  out  1  latched type of the granted request.
- cache_done  in  1  lookup finished (single-cycle pulse).
- cache_hit  in  1  result; valid only with cache_done.
- resp_valid  out  NREQ  one-hot response pulse.
- resp_hit  out  1  hit result; qualified by resp_valid.
- resp_err  out  1  timeout flag; qualified by resp_valid.
- num_reads  out  CNT_W  completed reads.
- num_writes  out  CNT_W  completed writes.
- num_misses  out  CNT_W  completed misses (includes timeouts).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - state = IDLE; rr_ptr = 0; wait_cnt = 0.
  - req_ready, resp_valid, resp_hit, resp_err, cache_valid = 0.
  - cache_addr, cache_write, num_reads, num_writes, num_misses = 0.
- Reset mid-operation: an in-flight request is abandoned with no response and no counter update; a late cache_done is ignored.

- State IDLE:
  - If any req_valid is set, select g = the first set index scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  - Assert req_ready[g] combinationally in that cycle; this is the transfer cycle.
  - On that edge, latch req_addr[g] into cache_addr, req_write[g] into cache_write, and g into grant.
  - Next state ISSUE. With no req_valid, stay in IDLE.
- State ISSUE:
  - cache_valid = 1. cache_addr and cache_write stay stable until the handshake completes.
  - When cache_valid && cache_ready: next state WAIT and clear wait_cnt. Otherwise hold in ISSUE (no timeout here).
- State WAIT:
  - cache_valid = 0; wait_cnt increments every cycle.
  - If cache_done: register hit = cache_hit, set err = 0, go to RESP.
  - Else if wait_cnt == TIMEOUT-1: set hit = 0, err = 1, go to RESP.
  - cache_done in the same cycle as the timeout wins (normal completion).
- State RESP, one cycle:
  - Drive resp_valid[grant] = 1, resp_hit = hit, resp_err = err.
  - Update counters on this edge:
    - num_reads += 1 if !cache_write.
    - num_writes += 1 if cache_write.
    - num_misses += 1 if !hit.
  - All counters saturate at 2^CNT_W-1.
  - rr_ptr <= (grant+1) mod NREQ. Next state IDLE.
- cache_done outside WAIT is ignored.
- Latency: transfer at cycle T, cache_valid high at T+1. If cache_ready=1 at T+1 and cache_done arrives at T+2, resp_valid is high at T+3. Minimum request-to-request spacing is 4 cycles.
- Fairness: a requester that loses arbitration is served within NREQ grants.
- req_valid dropping while waiting in IDLE is legal and cancels that request. Requesters must hold req_addr/req_write stable while req_valid is high.

Test Plan:
- Single read, requester 0 addr 0x0000_1040, cache_ready=1, cache_done+cache_hit=1 one cycle after the handshake -> req_ready[0] at T, cache_valid at T+1, resp_valid=01 with resp_hit=1 at T+3; num_reads=1, num_misses=0.
- Both requesters valid continuously (addrs 0x100 and 0x200), 4 transactions -> grant order 0,1,0,1; cache_addr sequence 0x100, 0x200, 0x100, 0x200.
- cache_ready held low 5 cycles in ISSUE -> cache_valid stays high with cache_addr unchanged for 6 cycles; no timeout fires.
- TIMEOUT=8, no cache_done -> resp_valid after 8 WAIT cycles with resp_hit=0, resp_err=1, num_misses=1. A later stray cache_done changes nothing.
- CNT_W=4, 20 write misses -> num_writes=15, num_misses=15 (saturated), num_reads=0.
- Reset asserted in WAIT -> next cycle all outputs 0 and state IDLE; no resp_valid is produced; the next request is granted to requester 0.
